// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory as big-endian 32-bit words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;
`endif

    state_t           state;
    state_t           state_d;
    logic [7:0]       len_hi;
    logic [15:0]      len;
    logic [1:0]       byte_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [23:0]      shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    logic        accept_c;
    logic        start_load_c;
    logic [15:0] len_word_c;
    logic        len_bad_c;
    logic        last_byte_c;
    logic        last_word_c;
    logic        active_d_c;

    // Handshake and length/position decodes
    always_comb begin
        accept_c     = in_valid && in_ready;
        len_word_c   = {len_hi, in_data};
        len_bad_c    = (len_word_c == 16'd0) || (32'(len_word_c) > DEPTH);
        last_byte_c  = (byte_cnt == 2'd3);
        last_word_c  = ((32'(word_cnt) + 32'd1) == 32'(len));
        start_load_c = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    end

    // Next-state logic
    always_comb begin
        state_d    = state;
        active_d_c = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
            S_LEN_HI: if (accept_c) state_d = S_LEN_LO;
            S_LEN_LO: if (accept_c) state_d = len_bad_c ? S_ERR : S_DATA;
            S_DATA: begin
                if (accept_c && last_byte_c && last_word_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: if (accept_c) state_d = (in_data == csum) ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
        active_d_c = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Registered outputs and word assembly datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            len_hi   <= '0;
            len      <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            shift    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            in_ready <= active_d_c;
            busy     <= active_d_c;
            done     <= (state_d == S_DONE) && (state != S_DONE);
            err      <= (state_d == S_ERR);
            wr_en    <= 1'b0;
            if (start_load_c) begin
                byte_cnt <= '0;
                word_cnt <= '0;
                wr_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (accept_c) begin
                case (state)
                    S_LEN_HI: len_hi <= in_data;
                    S_LEN_LO: len    <= len_word_c;
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {shift[15:0], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        if (last_byte_c) begin
                            wr_en    <= 1'b1;
                            wr_data  <= {shift, in_data};
                            wr_addr  <= word_cnt[ADDR_W-1:0];
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, which sets the instruction-memory word-address width (depth 2^ADDR_W = 256 words).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-005 The module SHALL have port in_data, input, 8 bits: serial image byte.
REQ-006 The module SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-008 The module SHALL have port wr_en, output, 1 bit: instruction-memory write strobe.
REQ-009 The module SHALL have port wr_addr, output, ADDR_W bits: instruction-memory word address.
REQ-010 The module SHALL have port wr_data, output, 32 bits: instruction word to write.
REQ-011 The module SHALL have port busy, output, 1 bit: load in progress; it holds the CPU in reset.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-013 The module SHALL have port err, output, 1 bit: level error flag, held until the next start or rst.

Function
REQ-014 A byte SHALL be accepted only on a cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 only in states LEN_HI, LEN_LO, DATA and CSUM.
REQ-015 The state machine SHALL be IDLE -> LEN_HI -> LEN_LO -> DATA -> (CSUM) -> DONE, with an ERR state; start in IDLE, DONE or ERR SHALL go to LEN_HI, clear err, and zero the address and byte counters.
REQ-016 start in LEN_HI, LEN_LO, DATA or CSUM SHALL be ignored.
REQ-017 The LEN_HI and LEN_LO bytes SHALL form a 16-bit word count N, most significant byte first.
REQ-018 If N = 0 or N > 2^ADDR_W, the machine SHALL go to ERR on the cycle after LEN_LO is accepted, and perform no writes.
REQ-019 In DATA, the first byte of each group of 4 SHALL land in wr_data[31:24] and the last in wr_data[7:0] (big-endian).
REQ-020 wr_en SHALL pulse high for exactly one cycle, on the cycle after the 4th byte of a word is accepted, with wr_addr and wr_data stable for that cycle.
REQ-021 wr_addr SHALL be 0 for the first word and increment by 1 after each write; it SHALL NOT wrap, because N is bounded by REQ-018.
REQ-022 in_ready SHALL remain 1 during the write cycle, so back-to-back bytes with no gaps are sustained.
REQ-023 After word N is accepted, the machine SHALL go to CSUM when checksumming is enabled, and to DONE otherwise.
REQ-024 On entering DONE, done SHALL pulse for 1 cycle and busy SHALL drop that same cycle; DONE SHALL then wait for start.
REQ-025 busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-026 Neither in ERR nor during a partially received word SHALL the machine issue any further writes.

Reset
REQ-027 When rst = 1, the module SHALL immediately enter IDLE and force in_ready, wr_en, busy, done and err to 0, and wr_addr and wr_data to 0.
REQ-028 Reset during a load SHALL discard any partial word; words already written SHALL remain in memory.

Configuration
REQ-029 With macro IMEM_LOADER_CHECKSUM_EN defined, the module SHALL keep a running XOR of all DATA bytes, and one trailing byte SHALL be accepted in CSUM.
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined, a trailing byte equal to the running XOR SHALL lead to DONE, and any other value SHALL lead to ERR with err = 1 and no done pulse.
REQ-031 Without IMEM_LOADER_CHECKSUM_EN, the CSUM state and the XOR register SHALL be absent, and DATA SHALL go directly to DONE after word N.

Verification
REQ-032 start, then bytes 00 01 12 34 56 78 [CSUM 08] -> one wr_en with wr_addr=0 and wr_data=0x12345678; done pulses once; busy falls.
REQ-033 N=2 streamed with no gaps -> writes at addr 0 then addr 1 exactly 4 cycles apart; in_ready stays 1 throughout.
REQ-034 Length bytes 00 00, and separately 01 01 -> err=1, no wr_en, in_ready=0, busy=0.
REQ-035 With IMEM_LOADER_CHECKSUM_EN defined, word 0x12345678 followed by checksum byte 0x09 -> err=1 and no done pulse; with byte 0x08 -> done pulses.
REQ-036 rst asserted after 2 of 4 data bytes, then start and a full image -> no stray write from the partial word; the new image loads from addr 0.
REQ-037 start pulsed during DATA -> ignored; the load completes normally.
